// File: rtl/mcu_spi_pkg.sv
// Shared types and widths for the MCU-link SPI initiator.
package mcu_spi_pkg;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned GAP_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StWait,
    StHold,
    StGap
  } state_t;

endpackage

// File: rtl/mcu_spi_master_if.sv
// Full-duplex byte stream between a client and the SPI initiator.
interface mcu_spi_master_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;

  // Client side drives bytes in and collects received bytes.
  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  // The SPI initiator itself.
  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/sync_fall.sv
// Two-flop synchroniser preset to 1, with a one-cycle pulse on the synchronised falling edge.
module sync_fall (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic s1_q, s2_q, fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      // Fires in the same cycle s2_q first reads low.
      fall_q <= s2_q & ~s1_q;
    end
  end

  assign q_o    = s2_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/mcu_spi_master.sv
// Mode-0 SPI initiator for the MCU link: byte stream in/out, csn framing on tx_last, intn watch.
module mcu_spi_master
  import mcu_spi_pkg::*;
#(
  parameter int unsigned DIV = 2,
  parameter int unsigned GAP = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  mcu_spi_master_if.slave    stream,
  output logic               busy,
  output logic               spi_sclk,
  output logic               spi_csn,
  output logic               spi_mosi,
  input  logic               spi_miso,
  input  logic               spi_intn,
  output logic               irq,
  output logic               intn_sync
);

  localparam logic [DIV_W-1:0] HP_LOAD  = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP * DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] hp_cnt_q, hp_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [6:0]       tx_sh_q, tx_sh_d;
  logic [6:0]       rx_sh_q, rx_sh_d;
  logic             last_q, last_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             tx_ready;
  logic             accept;

  assign tx_ready = (state_q == StIdle) || (state_q == StWait);
  assign accept   = stream.tx_valid && tx_ready;

  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = hp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      StIdle, StWait: begin
        if (accept) begin
          tx_sh_d   = stream.tx_data[6:0];
          last_d    = stream.tx_last;
          mosi_d    = stream.tx_data[7];
          csn_d     = 1'b0;
          sclk_d    = 1'b0;
          hp_cnt_d  = HP_LOAD;
          bit_cnt_d = 3'd0;
          state_d   = StShiftLo;
        end
      end
      StShiftLo: begin
        if (hp_cnt_q == '0) begin
          sclk_d   = 1'b1;
          hp_cnt_d = HP_LOAD;
          state_d  = StShiftHi;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      StShiftHi: begin
        if (hp_cnt_q == '0) begin
          // Sample at the end of the high phase so the target has the whole phase to settle.
          rx_sh_d   = {rx_sh_q[5:0], spi_miso};
          sclk_d    = 1'b0;
          hp_cnt_d  = HP_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
            state_d = StShiftLo;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_sh_q, spi_miso};
            state_d    = last_q ? StHold : StWait;
          end
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (hp_cnt_q == '0) begin
          csn_d     = 1'b1;
          gap_cnt_d = GAP_LOAD;
          state_d   = StGap;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      hp_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign stream.tx_ready = tx_ready;
  assign stream.rx_valid = rx_valid_q;
  assign stream.rx_data  = rx_data_q;
  assign busy            = (state_q != StIdle);
  assign spi_sclk        = sclk_q;
  assign spi_csn         = csn_q;
  assign spi_mosi        = mosi_q;

  sync_fall u_intn_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (spi_intn),
    .q_o     (intn_sync),
    .fall_o  (irq)
  );

endmodule

// File: tb/tb_mcu_spi_master.sv
// Self-checking bench for mcu_spi_master: SPI target model, directed and random frames.
module tb_mcu_spi_master;

  localparam int unsigned DIV = 2;
  localparam int unsigned GAP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mcu_spi_master_if bus ();
  mcu_spi_master_if bus1 ();

  logic busy, sclk, csn, mosi, miso, intn, irq, isync;
  logic busy1, sclk1, csn1, mosi1, irq1, isync1;
  logic intn1 = 1'b1;

  mcu_spi_master #(.DIV(DIV), .GAP(GAP)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stream    (bus.slave),
    .busy      (busy),
    .spi_sclk  (sclk),
    .spi_csn   (csn),
    .spi_mosi  (mosi),
    .spi_miso  (miso),
    .spi_intn  (intn),
    .irq       (irq),
    .intn_sync (isync)
  );

  // DIV=1 instance with MISO looped back to MOSI.
  mcu_spi_master #(.DIV(1), .GAP(1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .stream    (bus1.slave),
    .busy      (busy1),
    .spi_sclk  (sclk1),
    .spi_csn   (csn1),
    .spi_mosi  (mosi1),
    .spi_miso  (mosi1),
    .spi_intn  (intn1),
    .irq       (irq1),
    .intn_sync (isync1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 target: captures MOSI on rising sclk, presents response MSB first, advancing on falling.
  logic [7:0] t_resp = 8'h00;
  logic [2:0] t_bit = 3'd0;
  logic [7:0] t_cap = 8'h00;
  int rise_cnt = 0;
  int csn_rise = 0;
  int rxv_cnt = 0;

  assign miso = t_resp[3'd7 - t_bit];

  always @(posedge sclk) if (!csn) begin
    t_cap = {t_cap[6:0], mosi};
    rise_cnt++;
  end
  always @(negedge sclk or posedge csn) begin
    if (csn) t_bit = 3'd0;
    else     t_bit = t_bit + 3'd1;
  end
  always @(posedge csn) csn_rise++;
  always @(posedge clk) if (bus.rx_valid === 1'b1) rxv_cnt++;

  logic [7:0] txq [4];
  logic [7:0] rsq [4];

  // Runs one frame of n bytes from txq/rsq; stall>0 drops tx_valid that many cycles between bytes.
  task automatic frame(input int n, input int stall, input string tag);
    int cyc;
    @(negedge clk);
    rise_cnt = 0;
    csn_rise = 0;
    rxv_cnt  = 0;
    t_resp   = rsq[0];
    bus.tx_valid = 1'b1;
    bus.tx_data  = txq[0];
    bus.tx_last  = (n == 1);
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (bus.tx_ready !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
      check({tag, " ready_timeout"}, 32'(cyc < 2000), 32'd1);
      @(posedge clk); #1;
      if (i == n - 1 || stall > 0) bus.tx_valid = 1'b0;
      cyc = 0;
      while (bus.rx_valid !== 1'b1 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
      check({tag, " latency"}, cyc, 16 * DIV);
      check({tag, " rx_data"}, bus.rx_data, rsq[i]);
      check({tag, " mosi_bits"}, t_cap, txq[i]);
      if (i < n - 1) begin
        t_resp       = rsq[i+1];
        bus.tx_data  = txq[i+1];
        bus.tx_last  = (i + 1 == n - 1);
        if (stall > 0) begin
          repeat (stall) @(posedge clk);
          #1;
          check({tag, " wait_csn"}, csn, 1'b0);
          check({tag, " wait_sclk"}, sclk, 1'b0);
          check({tag, " wait_ready"}, bus.tx_ready, 1'b1);
          bus.tx_valid = 1'b1;
        end
      end
    end
    cyc = 0;
    while (csn !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check({tag, " csn_release"}, cyc, DIV);
    check({tag, " busy_gap"}, busy, 1'b1);
    cyc = 0;
    while (bus.tx_ready !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check({tag, " gap_len"}, cyc, GAP * DIV);
    check({tag, " busy_idle"}, busy, 1'b0);
    check({tag, " rise_edges"}, rise_cnt, 8 * n);
    check({tag, " csn_rises"}, csn_rise, 1);
    check({tag, " rx_strobes"}, rxv_cnt, n);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int flag;
    int n;
    int stall;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_last = 1'b0;
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00; bus1.tx_last = 1'b0;
    intn = 1'b1;

    #2 reset_n = 1'b0;
    #1;
    check("rst csn", csn, 1'b1);
    check("rst sclk", sclk, 1'b0);
    check("rst mosi", mosi, 1'b0);
    check("rst rx_valid", bus.rx_valid, 1'b0);
    check("rst rx_data", bus.rx_data, 8'h00);
    check("rst irq", irq, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst intn_sync", isync, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst tx_ready", bus.tx_ready, 1'b1);

    txq[0] = 8'hA5; rsq[0] = 8'h3C;
    frame(1, 0, "single");

    txq[0] = 8'h01; txq[1] = 8'hFF; rsq[0] = 8'h5A; rsq[1] = 8'hC6;
    frame(2, 0, "pair");

    txq[0] = 8'h55; txq[1] = 8'h80; rsq[0] = 8'h96; rsq[1] = 8'h0F;
    frame(2, 50, "stall");

    // Reset during the 4th bit.
    @(negedge clk);
    rise_cnt = 0;
    t_resp = 8'hE7;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h9A; bus.tx_last = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    cyc = 0;
    while (!(rise_cnt == 3 && sclk === 1'b0) && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("midrst reach_bit4", 32'(cyc < 200), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst csn", csn, 1'b1);
    check("midrst sclk", sclk, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst rx_data", bus.rx_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst tx_ready", bus.tx_ready, 1'b1);
    check("midrst busy_after", busy, 1'b0);
    txq[0] = 8'h12; rsq[0] = 8'hB4;
    frame(1, 0, "after_rst");

    // intn path.
    @(posedge clk); #3;
    intn = 1'b0;
    cyc = 0;
    while (irq !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("irq delay_ok", 32'(cyc >= 2 && cyc <= 3), 32'd1);
    check("irq intn_sync_low", isync, 1'b0);
    @(posedge clk); #1;
    check("irq single_pulse", irq, 1'b0);
    repeat (3) @(posedge clk);
    #3 intn = 1'b1;
    flag = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) flag = 1;
    end
    check("irq none_on_rise", flag, 0);
    check("irq intn_sync_high", isync, 1'b1);

    // DIV=1 loopback.
    @(negedge clk);
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'hC3; bus1.tx_last = 1'b1;
    @(posedge clk); #1;
    bus1.tx_valid = 1'b0;
    check("div1 csn_low", csn1, 1'b0);
    cyc = 0;
    while (bus1.rx_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("div1 latency", cyc, 16);
    check("div1 rx_data", bus1.rx_data, 8'hC3);
    cyc = 0;
    while (bus1.tx_ready !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("div1 back_idle", cyc, 2);

    // Random frames with optional stalls.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 3);
      stall = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      for (int b = 0; b < 4; b++) begin
        txq[b] = 8'($urandom);
        rsq[b] = 8'($urandom);
      end
      frame(n, stall, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcu_spi_master.md
Name: mcu_spi_master

Overview:
- SPI initiator for the MCU link: it drives sclk, csn and mosi, samples miso, and watches intn.
- It is the counterpart of the FPGA-side MCU SPI target in misterynano.
- It serves two roles:
  - an on-chip soft-MCU/bring-up master on boards without the BL616/M0S;
  - a bus-functional driver in core-level simulation.
- Bytes are exchanged full-duplex through a valid/ready stream. Frame end is marked by tx_last.

Parameters:
DIV, 2, clk cycles per sclk half-period; legal range 1..255.
GAP, 2, minimum csn-high time between frames, in sclk half-periods; at least 1.

Ports:
clk  in  1  system clock (clk32 domain)
reset_n  in  1  asynchronous active-low reset
tx_valid  in  1  tx_data/tx_last valid
tx_ready  out  1  master accepts a byte this cycle
tx_data  in  8  byte to shift out, MSB first
tx_last  in  1  last byte of frame; csn released after it
rx_valid  out  1  one-cycle strobe, rx_data valid
rx_data  out  8  byte shifted in during the same transfer
busy  out  1  high while csn low or inter-frame gap running
spi_sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_csn  out  1  chip select, active low
spi_mosi  out  1  master out
spi_miso  in  1  master in
spi_intn  in  1  target interrupt, active low, asynchronous
irq  out  1  one-cycle pulse on synchronised intn falling edge
intn_sync  out  1  synchronised intn level

Behaviour:
- Reset (asynchronous, effective immediately, including mid-frame):
  - spi_csn=1, spi_sclk=0, spi_mosi=0.
  - rx_valid=0, rx_data=0, irq=0, busy=0.
  - intn_sync=1; both synchroniser flops preset to 1.
  - state=IDLE, so tx_ready=1 once reset is released.
- States: IDLE, SHIFT_LO, SHIFT_HI, WAIT, HOLD, GAP.
- tx_ready=1 only in IDLE and WAIT. A byte is accepted on tx_valid&&tx_ready; tx_data and tx_last are latched.
- Accept in IDLE at edge t:
  - from t+1: csn=0, mosi=tx_data[7], sclk=0, state SHIFT_LO.
  - The first low phase doubles as csn setup.
- SHIFT_LO:
  - lasts DIV cycles, then sclk=1 and state SHIFT_HI.
- SHIFT_HI:
  - lasts DIV cycles.
  - miso is sampled into the shift register on the last cycle of the high phase, so the target has the whole high phase to settle.
  - Then sclk=0:
    - if the bit count is below 8, mosi takes the next bit and state returns to SHIFT_LO;
    - after the 8th bit, rx_valid pulses with the full byte in the cycle sclk returns low.
- Timing: 16*DIV cycles from csn low (or from WAIT accept) to rx_valid.
- After byte end:
  - tx_last=0: go to WAIT (csn low, sclk low, mosi holds last bit).
  - tx_last=1: go to HOLD.
- WAIT:
  - waits indefinitely.
  - An accept sets mosi=bit7 on the next cycle and enters SHIFT_LO with identical timing.
- HOLD: DIV cycles with csn low and sclk low, then csn=1 and state GAP.
- GAP:
  - GAP*DIV cycles with csn high, then IDLE.
  - tx_valid is ignored during GAP, since tx_ready=0.
- busy=1 in every state except IDLE.
- Counters:
  - half-period counter is 8 bits, counts DIV-1 down to 0;
  - bit counter is 3 bits and wraps 7→0 at byte end;
  - gap counter is 16 bits.
- rx_data holds its value until the next byte completes.
- intn path:
  - 2-flop synchroniser; intn_sync is the second flop.
  - irq=1 for one cycle when intn_sync goes 1→0.
  - The path is independent of the SPI state and keeps running during transfers.
- DIV=1: sclk = clk/2. Sampling then occurs in the single high cycle.

Decomposition:
- Package mcu_spi_pkg holds:
  - state typedef (state_t enum of the six states);
  - DIV_W=8 and GAP_W=16 width constants.
- One sub-module, sync_fall: 2-flop synchroniser with preset-to-1 and a falling-edge pulse. It is reused for intn.
- The shift engine stays in mcu_spi_master.

Test Plan:
- Single byte, DIV=2, tx_data=0xA5, tx_last=1, target returns 0x3C → sclk edges: 8 rising; mosi bits 1,0,1,0,0,1,0,1; rx_valid 32 cycles after csn low with rx_data=0x3C; csn high 2 cycles later; tx_ready back after 4 more cycles.
- Two-byte frame 0x01 then 0xFF (last), tx_valid held continuously → csn stays low across both bytes; exactly 16 rising sclk edges; two rx_valid strobes.
- Stalled frame: byte 0x55 with tx_last=0, tx_valid low for 50 cycles → WAIT with csn=0, sclk=0, tx_ready=1; next byte 0x80 (last) completes normally.
- Reset asserted during the 4th bit → csn=1 and sclk=0 in the same cycle; after release tx_ready=1, busy=0, and a new byte 0x12 transfers correctly.
- spi_intn driven low asynchronously, 5 cycles → irq is a single pulse 2–3 cycles later; no pulse on rising; intn_sync follows.
- DIV=1, byte 0xC3 loopback (miso=mosi) → rx_data=0xC3; 16 cycles from csn low to rx_valid.
